bfj_stage_ctrl: RTL
===================

Name: bfj_stage_ctrl

Overview:
- Sequences one radix-2 FFT stage built around the trivial-twiddle butterfly (up/down sum/difference, optional -j rotation on the difference path, 1-cycle registered output).
- Accepts a frame start, counts N/2 butterfly pairs under a valid/ready handshake, and drives the butterfly's twiddle select per pair.
- Produces output valid, index and last flags aligned to the butterfly's 1-cycle latency, plus a frame-done pulse for the next stage or memory controller.

Parameters:
- N, 128, FFT size in points; power of 2, at least 8.
- Q, 16, twiddle run length in pairs; power of 2, 1 ≤ Q ≤ N/4.
- FCW, 16, width of the completed-frame counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  frame start request; sampled in IDLE only.
- in_valid  in  1  upstream presents an up/down sample pair this cycle.
- in_ready  out  1  controller accepts a pair this cycle.
- twd  out  1  butterfly twiddle select; 1 = plain difference, 0 = difference × (-j).
- pair_idx  out  log2(N)-1  index of the pair being presented to the butterfly.
- out_valid  out  1  butterfly output registers hold a valid result.
- out_idx  out  log2(N)-1  pair index of the result in the butterfly output registers.
- out_last  out  1  result is pair N/2-1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at frame completion.
- frame_cnt  out  FCW  completed-frame count (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high; the reset port is rst and the clock is clk.
  - State = IDLE, pair counter = 0.
  - in_ready=0, out_valid=0, out_idx=0, out_last=0, done=0, busy=0, frame_cnt=0.
  - twd=1 and pair_idx=0 (combinational from the zeroed counter).
- FSM states:
  - IDLE → RUN when start=1.
  - RUN → DRAIN when pair N/2-1 is accepted.
  - DRAIN → IDLE unconditionally after 1 cycle; done=1 during DRAIN.
- Handshake and counter:
  - in_ready = (state==RUN), combinational.
  - A pair is accepted when in_valid & in_ready.
  - The pair counter increments only on accept. It wraps to 0 on the last accept.
  - in_valid=0 in RUN stalls: the counter holds.
- twd and pair_idx:
  - pair_idx = counter, combinational.
  - twd = ~counter[log2(Q)], combinational.
  - Result: runs of Q pairs at twd=1 alternate with runs of Q pairs at twd=0, starting at twd=1.
  - Q=1 alternates every pair.
  - The same twd and pair_idx are valid in IDLE/DRAIN but are don't-care to the datapath.
- Output alignment (latency 1, matching the butterfly register):
  - out_valid, out_idx and out_last are registered from the accept condition, counter, and (counter==N/2-1).
  - out_valid=1 exactly the cycle after each accept; 0 otherwise.
  - out_idx and out_last hold their last value when out_valid=0.
- done: asserted in DRAIN. It coincides with out_valid=1, out_last=1 for pair N/2-1.
- Boundary conditions:
  - start while RUN/DRAIN is ignored; no queuing.
  - start held high continuously gives back-to-back frames separated by exactly one DRAIN cycle and one IDLE cycle.
  - in_valid while IDLE/DRAIN is not accepted and produces no out_valid.
  - Stall on the last pair: stay in RUN until it is accepted.
  - rst mid-frame: immediate return to reset values. A partially issued frame is abandoned; no done, no frame_cnt increment.

Optional Feature:
- Macro BFJ_STAGE_CTRL_FRMCNT_EN.
- Defined:
  - frame_cnt increments by 1 in the cycle done=1.
  - Wraps modulo 2^FCW.
  - Cleared only by rst.
- Undefined: frame_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then start=0 for 10 cycles → in_ready=0, out_valid=0, busy=0, done=0, twd=1, frame_cnt=0 throughout.
- Full frame, N=128, Q=16, in_valid held 1:
  - start pulse → in_ready=1 for 64 cycles.
  - twd=1 for pairs 0-15 and 32-47; twd=0 for pairs 16-31 and 48-63.
  - out_valid=1 on 64 consecutive cycles, starting 1 cycle after the first accept.
  - out_idx runs 0..63; out_last=1 and done=1 only with out_idx=63.
- Stalls: in_valid toggles 1,0,0,1 repeating over a frame → the counter holds during gaps; out_valid mirrors accepts delayed by 1 cycle; 64 results, none duplicated or skipped; done is delayed accordingly.
- Q=1, N=8: 4 pairs → twd sequence 1,0,1,0; out_idx 0,1,2,3; done with idx 3.
- Start held 1 for 3 frames, with FRMCNT_EN defined → frames separated by 2 idle cycles (DRAIN+IDLE); frame_cnt reads 1, 2, 3 after each done; start asserted during RUN does not reset the counter.
- Reset mid-frame: assert rst at pair 20 → outputs return to reset values asynchronously (before the next clk edge); no done; frame_cnt unchanged at 0; the next start runs a full frame from pair 0.

Source files
------------

// File: rtl/bfj_stage_ctrl.sv
// Sequencer for one radix-2 FFT stage around the trivial-twiddle butterfly.
// Optional completed-frame counter: BFJ_STAGE_CTRL_FRMCNT_EN.
module bfj_stage_ctrl #(
    parameter int N   = 128,
    parameter int Q   = 16,
    parameter int FCW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   twd,
    output logic [$clog2(N)-2:0]   pair_idx,
    output logic                   out_valid,
    output logic [$clog2(N)-2:0]   out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [FCW-1:0]         frame_cnt
);

    localparam int CW = $clog2(N) - 1;
    localparam int QB = $clog2(Q);
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          cnt_last;

    assign in_ready = (state == RUN);
    assign accept   = in_valid & in_ready;
    assign cnt_last = (cnt == LAST);
    assign busy     = (state != IDLE);
    assign done     = (state == DRAIN);
    assign pair_idx = cnt;
    // Bit log2(Q) flips every Q pairs, giving alternating twiddle runs.
    assign twd      = ~cnt[QB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && cnt_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    // Mirrors the butterfly's single output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_idx  <= cnt;
                out_last <= cnt_last;
            end
        end
    end

`ifdef BFJ_STAGE_CTRL_FRMCNT_EN
    logic [FCW-1:0] fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if (state == DRAIN) begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign frame_cnt = fcnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
